// File: rtl/score_display_ctrl.sv
// Score display controller: serial double-dabble conversion of the live or best
// score, hi-score tracking, and a multiplexed 3-digit seven-segment driver.
module score_display_ctrl #(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score,
    input  logic       game_end,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic [7:0] hi_score,
    output logic       new_record,
    output logic       busy
);

    typedef enum logic {IDLE, CONV} state_t;

    localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_DIV - 1);

    state_t      state, state_nxt;
    logic [7:0]  conv_src, conv_src_nxt;
    logic [19:0] shift_reg, shift_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [11:0] disp_bcd, disp_bcd_nxt;
    logic        prev_end;
    logic [15:0] scan_cnt;
    logic [1:0]  digit_idx;
    logic [7:0]  blink_cnt;
    logic        blink_phase;
    logic        scan_wrap;
    logic [7:0]  src;
    logic [19:0] dabble;
    logic [3:0]  digit;
    logic        blank;
    logic [6:0]  seg_nxt;
    logic [2:0]  an_nxt;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

    assign src  = game_end ? score : hi_score;
    assign busy = (state == CONV);

    // Shift register layout: [19:8] BCD hundreds/tens/ones, [7:0] binary bits still to shift in.
    always_comb begin
        dabble = shift_reg;
        for (int n = 0; n < 3; n++) begin
            if (dabble[8+4*n +: 4] >= 4'd5)
                dabble[8+4*n +: 4] = dabble[8+4*n +: 4] + 4'd3;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_nxt    = state;
        conv_src_nxt = conv_src;
        shift_nxt    = shift_reg;
        bit_cnt_nxt  = bit_cnt;
        disp_bcd_nxt = disp_bcd;
        case (state)
            IDLE: begin
                if (src != conv_src) begin
                    conv_src_nxt = src;
                    shift_nxt    = {12'd0, src};
                    bit_cnt_nxt  = 4'd0;
                    state_nxt    = CONV;
                end
            end
            CONV: begin
                shift_nxt   = {dabble[18:0], 1'b0};
                bit_cnt_nxt = bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                    disp_bcd_nxt = dabble[18:7];
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            conv_src  <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            disp_bcd  <= '0;
        end else begin
            state     <= state_nxt;
            conv_src  <= conv_src_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            disp_bcd  <= disp_bcd_nxt;
        end
    end

    // A record needs a strictly higher score on the rising edge of game_end.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_score   <= '0;
            new_record <= 1'b0;
            prev_end   <= 1'b0;
        end else begin
            prev_end <= game_end;
            if (game_end && !prev_end && (score > hi_score)) begin
                hi_score   <= score;
                new_record <= 1'b1;
            end else if (!game_end && prev_end) begin
                new_record <= 1'b0;
            end
        end
    end

    assign scan_wrap = (scan_cnt == SCAN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt    <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            scan_cnt <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
            if (scan_wrap) begin
                digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

    // Leading zeros are blanked; the ones digit is always lit.
    always_comb begin
        digit  = disp_bcd[3:0];
        blank  = 1'b0;
        an_nxt = 3'b111;
        case (digit_idx)
            2'd0: begin
                digit  = disp_bcd[3:0];
                an_nxt = 3'b110;
            end
            2'd1: begin
                digit  = disp_bcd[7:4];
                blank  = (disp_bcd[11:4] == 8'd0);
                an_nxt = 3'b101;
            end
            2'd2: begin
                digit  = disp_bcd[11:8];
                blank  = (disp_bcd[11:8] == 4'd0);
                an_nxt = 3'b011;
            end
            default: blank = 1'b1;
        endcase
        if (new_record && blink_phase)
            an_nxt = 3'b111;
        seg_nxt = blank ? SEG_BLANK : seg_encode(digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= 3'b111;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: scoreboarded BCD conversions,
// table-driven display vectors and hand-written record/reset/scan sequences.
module tb_score_display_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    localparam logic [6:0] S_BL = 7'b1111111;
    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] score;
    logic       game_end;
    logic [6:0] seg;
    logic [2:0] an;
    logic [7:0] hi_score;
    logic       new_record;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic [7:0]  score;
        logic [11:0] bcd;
        logic [6:0]  seg_h;
        logic [6:0]  seg_t;
        logic [6:0]  seg_o;
    } vec_t;
    vec_t vecs[8];

    logic [2:0] an_cycle[3];

    score_display_ctrl #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .score      (score),
        .game_end   (game_end),
        .seg        (seg),
        .an         (an),
        .hi_score   (hi_score),
        .new_record (new_record),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts busy-high negedges until busy falls, then pops the scoreboard.
    task automatic wait_conv(input string name, input int exp_len);
        int n = 0;
        int guard = 0;
        logic [11:0] exp_bcd;
        while (guard < 40) begin
            @(negedge clk);
            guard++;
            if (busy === 1'b1) n++;
            else if (n > 0) break;
        end
        check({name, " busy_len"}, n, exp_len);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected entry", name);
        end else begin
            exp_bcd = exp_q.pop_front();
            check({name, " disp_bcd"}, dut.disp_bcd, exp_bcd);
        end
    endtask

    task automatic capture_digits(input string name, input logic [6:0] eh,
                                  input logic [6:0] et, input logic [6:0] eo);
        logic [6:0] got[3] = '{default: 'x};
        bit seen[3] = '{default: 1'b0};
        for (int c = 0; c < 200 && !(seen[0] && seen[1] && seen[2]); c++) begin
            @(negedge clk);
            case (an)
                3'b110: begin got[0] = seg; seen[0] = 1'b1; end
                3'b101: begin got[1] = seg; seen[1] = 1'b1; end
                3'b011: begin got[2] = seg; seen[2] = 1'b1; end
                default: ;
            endcase
        end
        check({name, " hundreds"}, got[2], eh);
        check({name, " tens"}, got[1], et);
        check({name, " ones"}, got[0], eo);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{8'd9,   12'h009, S_BL, S_BL, S9};
        vecs[1] = '{8'd10,  12'h010, S_BL, S1,   S0};
        vecs[2] = '{8'd99,  12'h099, S_BL, S9,   S9};
        vecs[3] = '{8'd100, 12'h100, S1,   S0,   S0};
        vecs[4] = '{8'd109, 12'h109, S1,   S0,   S9};
        vecs[5] = '{8'd255, 12'h255, S2,   S5,   S5};
        vecs[6] = '{8'd38,  12'h038, S_BL, S3,   S8};
        vecs[7] = '{8'd0,   12'h000, S_BL, S_BL, S0};
        an_cycle[0] = 3'b110;
        an_cycle[1] = 3'b101;
        an_cycle[2] = 3'b011;

        rst = 1'b1;
        game_end = 1'b0;
        score = 8'd0;
        repeat (2) @(negedge clk);
        check("reset seg", seg, S_BL);
        check("reset an", an, 3'b111);
        check("reset hi_score", hi_score, 8'd0);
        check("reset new_record", new_record, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset disp_bcd", dut.disp_bcd, 12'h000);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset ones seg", seg, S0);
        check("post-reset an", an, 3'b110);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) cnt++;
        end
        check("idle busy cycles", cnt, 0);
        capture_digits("idle zero", S_BL, S_BL, S0);

        // First game over with 200: record set on the rising edge, display blinks.
        score = 8'd200;
        game_end = 1'b1;
        exp_q.push_back(12'h200);
        @(negedge clk);
        check("rec200 hi_score", hi_score, 8'd200);
        check("rec200 new_record", new_record, 1'b1);
        check("rec200 busy", busy, 1'b1);
        wait_conv("rec200", 7);
        cnt = 0;
        repeat (32) begin
            @(negedge clk);
            if (an === 3'b111) cnt++;
        end
        check("rec200 blink blank cycles", cnt, 16);
        capture_digits("rec200", S2, S0, S0);

        // Lower score: record clears on the fall, is not set again on the rise.
        score = 8'd150;
        game_end = 1'b0;
        @(negedge clk);
        check("fall new_record", new_record, 1'b0);
        check("fall hi_score", hi_score, 8'd200);
        check("fall busy", busy, 1'b0);
        capture_digits("fall shows hi", S2, S0, S0);
        game_end = 1'b1;
        exp_q.push_back(12'h150);
        @(negedge clk);
        check("s150 new_record", new_record, 1'b0);
        check("s150 hi_score", hi_score, 8'd200);
        check("s150 busy", busy, 1'b1);
        wait_conv("s150", 7);
        capture_digits("s150", S1, S5, S0);

        // Equal score is not a record.
        game_end = 1'b0;
        exp_q.push_back(12'h200);
        wait_conv("back to hi", 8);
        score = 8'd200;
        game_end = 1'b1;
        @(negedge clk);
        check("equal new_record", new_record, 1'b0);
        check("equal busy", busy, 1'b0);
        check("equal hi_score", hi_score, 8'd200);

        foreach (vecs[i]) begin
            score = vecs[i].score;
            exp_q.push_back(vecs[i].bcd);
            wait_conv($sformatf("vec%0d", i), 8);
            capture_digits($sformatf("vec%0d", i), vecs[i].seg_h, vecs[i].seg_t, vecs[i].seg_o);
        end
        check("no-rise hi_score", hi_score, 8'd200);

        // Source changes mid-conversion: first result completes, then the new value converts.
        score = 8'd255;
        exp_q.push_back(12'h255);
        repeat (3) @(negedge clk);
        score = 8'd7;
        exp_q.push_back(12'h007);
        wait_conv("mid first", 5);
        wait_conv("mid second", 8);
        capture_digits("mid 7", S_BL, S_BL, S7);

        // Reset during a conversion.
        score = 8'd99;
        repeat (3) @(negedge clk);
        check("pre-abort busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", busy, 1'b0);
        check("abort hi_score", hi_score, 8'd0);
        check("abort new_record", new_record, 1'b0);
        check("abort seg", seg, S_BL);
        check("abort an", an, 3'b111);
        check("abort disp_bcd", dut.disp_bcd, 12'h000);
        game_end = 1'b0;
        score = 8'd0;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("scan an c%0d", i), an, an_cycle[(i / SCAN_DIV) % 3]);
            if (i == 0) check("scan first seg", seg, S0);
        end
        check("scan busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per digit scan slot, legal range 2..65535.
REQ-002 Parameter BLINK_DIV, default 64: scan-slot wraps per blink half-period, legal range 1..255.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 score  input  8  binary score from game FSM.
REQ-006 game_end  input  1  game-over flag from game timer.
REQ-007 seg  output  7  active-low segments, seg[0]=a .. seg[6]=g.
REQ-008 an  output  3  active-low one-hot digit enables; an[0]=ones, an[1]=tens, an[2]=hundreds.
REQ-009 hi_score  output  8  best score since reset.
REQ-010 new_record  output  1  last finished game set a new hi_score.
REQ-011 busy  output  1  BCD conversion in progress.

Function
REQ-012 Source value: src = score when game_end=1, else hi_score.
REQ-013 FSM states: IDLE and CONV only.
REQ-014 In IDLE, if src != conv_src at an edge, the block latches src into conv_src and the shift register, clears the 4-bit bit counter, and enters CONV.
REQ-015 In CONV, each edge performs one double-dabble step: add 3 to any BCD nibble >=5, then shift left by 1.
REQ-016 After exactly 8 CONV edges, the 12-bit result is written to disp_bcd and the FSM returns to IDLE.
REQ-017 Latency: a load at edge k updates disp_bcd at edge k+8; busy is 1 from after edge k through edge k+8, otherwise 0.
REQ-018 A src change during CONV does not abort the conversion; the new value is detected in IDLE on the next edge and converted.
REQ-019 A rising edge of game_end (game_end=1 and prev_end=0) with score > hi_score loads hi_score<=score and sets new_record=1 on the same edge.
REQ-020 A rising edge with score <= hi_score leaves hi_score and new_record unchanged; equality is not a record.
REQ-021 A falling edge of game_end clears new_record.
REQ-022 scan_cnt (16 bits) counts 0..SCAN_DIV-1 and wraps; on each wrap the digit index steps 0->1->2->0.
REQ-023 an drives the selected digit low (index 0: 3'b110, 1: 3'b101, 2: 3'b011).
REQ-024 seg encodes the selected BCD digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other value gives 1111111.
REQ-025 Leading-zero blanking: the hundreds digit shows seg=1111111 when it is 0; tens shows 1111111 when hundreds=0 and tens=0; ones is always shown.
REQ-026 blink_cnt increments on every scan wrap, wraps at BLINK_DIV-1, and toggles blink_phase on wrap.
REQ-027 While new_record=1 and blink_phase=1, an=3'b111; otherwise an follows REQ-023.
REQ-028 seg and an are registered, and change one edge after the index or data that drives them.

Reset
REQ-029 With rst=1 at an edge: FSM=IDLE; conv_src, shift register, disp_bcd, hi_score=0; new_record=0; busy=0; prev_end=0; scan_cnt, digit index, blink_cnt, blink_phase=0.
REQ-030 After reset: seg=1111111 (registered value), an=3'b111; display then shows "0" on the ones digit.
REQ-031 rst during CONV abandons the conversion; disp_bcd returns to 0.
REQ-032 rst takes precedence over every other event on the same edge.

Verification
REQ-033 Reset, game_end=0, score=0 -> busy stays 0, disp_bcd=0, ones digit seg=1000000, tens and hundreds digits blank.
REQ-034 score=200, game_end 0->1 -> hi_score=200 and new_record=1 on the same edge; busy high for 8 cycles; disp_bcd=0x200; digits show 2,0,0; an blanks while blink_phase=1.
REQ-035 Next, score=150, game_end 1->0->1 -> new_record cleared on the fall and not set on the rise; hi_score=200; display shows 150 while game_end=1 and 200 while game_end=0.
REQ-036 score=255 with game_end=1, changed to 7 mid-CONV -> disp_bcd=0x255 first, then 0x007 after the second conversion; hundreds and tens digits blanked.
REQ-037 SCAN_DIV=4: an cycles 110,101,011 with 4 clocks per slot; rst asserted mid-conversion -> all REQ-029 values on the next edge.
